pwm_multi_channel: RTL and testbench

Parametrised multi-channel PWM generator; successor to the single-channel fixed-speed PWM block.
- One shared counter drives CHANNELS outputs, each with its own programmable duty and polarity.
- Programmable period; edge-aligned or center-aligned mode.
- Double-buffered duty/period/mode registers, updated only at period boundaries, so outputs never glitch.
- Sits behind the tt_um top wrapper; the registers are loaded from dedicated inputs.

---
 rtl/pwm_multi_channel_if.sv | 28 ++
 rtl/pwm_multi_channel.sv | 113 +++++++++++
 tb/tb_pwm_multi_channel.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_channel_if.sv
// Register-load and output bundle for pwm_multi_channel.
// The master drives configuration and the slave (the PWM core) returns the outputs.
interface pwm_multi_channel_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                en;
  logic                mode;
  logic [CHANNELS-1:0] pol;
  logic                duty_we;
  logic [SEL_W-1:0]    duty_sel;
  logic [WIDTH-1:0]    duty_data;
  logic                period_we;
  logic [WIDTH-1:0]    period_data;
  logic [CHANNELS-1:0] pwm_out;
  logic                cycle_start;

  modport master (
    output en, mode, pol, duty_we, duty_sel, duty_data, period_we, period_data,
    input  pwm_out, cycle_start
  );

  modport slave (
    input  en, mode, pol, duty_we, duty_sel, duty_data, period_we, period_data,
    output pwm_out, cycle_start
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared edge/center-aligned counter and per-channel compare.
// Duty, period and mode are double-buffered and switch over only at period boundaries.
module pwm_multi_channel #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input logic               clk,
  input logic               rst_n,
  pwm_multi_channel_if.slave bus
);

  logic [WIDTH-1:0]                cnt_q, cnt_d;
  logic                            dir_q, dir_d;  // 0 = counting up, 1 = counting down
  logic [CHANNELS-1:0][WIDTH-1:0]  duty_pend_q, duty_pend_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  duty_act_q, duty_act_d;
  logic [WIDTH-1:0]                period_pend_q, period_pend_d;
  logic [WIDTH-1:0]                period_act_q, period_act_d;
  logic                            mode_act_q, mode_act_d;
  logic [CHANNELS-1:0]             pwm_out_q, pwm_out_d;
  logic                            cycle_start_q, cycle_start_d;

  logic                            boundary;
  logic                            load;
  logic [CHANNELS-1:0]             raw;

  assign boundary = (cnt_q == '0) && !dir_q;
  assign load     = !bus.en || boundary;

  always_comb begin
    duty_pend_d   = duty_pend_q;
    period_pend_d = period_pend_q;
    duty_act_d    = duty_act_q;
    period_act_d  = period_act_q;
    mode_act_d    = mode_act_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    raw           = '0;

    // Out-of-range duty_sel matches no channel, so such writes are dropped.
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (bus.duty_we && (bus.duty_sel == SEL_W'(i))) begin
        duty_pend_d[i] = bus.duty_data;
      end
    end
    if (bus.period_we) begin
      period_pend_d = bus.period_data;
    end

    // The *_d pending values already carry a same-cycle write, giving the bypass for free.
    // The mode input itself is the pending mode value.
    if (load) begin
      duty_act_d   = duty_pend_d;
      period_act_d = period_pend_d;
      mode_act_d   = bus.mode;
    end

    // Current-cycle decisions use *_act_d so a boundary cycle already runs on the new values.
    if (!bus.en) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (!mode_act_d) begin
      dir_d = 1'b0;
      cnt_d = (cnt_q >= period_act_d) ? '0 : cnt_q + WIDTH'(1);
    end else if (!dir_q) begin
      if (cnt_q >= period_act_d) begin
        dir_d = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else begin
      if (cnt_q == '0) begin
        dir_d = 1'b0;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      raw[i] = bus.en && (cnt_q < duty_act_d[i]);
    end
    pwm_out_d     = raw ^ bus.pol;
    cycle_start_d = boundary && bus.en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      duty_pend_q   <= '0;
      duty_act_q    <= '0;
      period_pend_q <= '1;
      period_act_q  <= '1;
      mode_act_q    <= 1'b0;
      pwm_out_q     <= '0;
      cycle_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      duty_pend_q   <= duty_pend_d;
      duty_act_q    <= duty_act_d;
      period_pend_q <= period_pend_d;
      period_act_q  <= period_act_d;
      mode_act_q    <= mode_act_d;
      pwm_out_q     <= pwm_out_d;
      cycle_start_q <= cycle_start_d;
    end
  end

  assign bus.pwm_out     = pwm_out_q;
  assign bus.cycle_start = cycle_start_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel: a position-based period model queues expected
// outputs per clock, plus directed high-time and cycle_start spacing checks.
module tb_pwm_multi_channel;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 2;

  logic clk;
  logic rst_n;

  pwm_multi_channel_if #(.CHANNELS(CH), .WIDTH(W), .SEL_W(SW)) bus ();

  pwm_multi_channel #(.CHANNELS(CH), .WIDTH(W), .SEL_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] pwm;
    logic          cs;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Model state: position within the current period plus pending/active copies.
  int m_pos;
  int m_pend_duty[CH];
  int m_act_duty[CH];
  int m_pend_p;
  int m_act_p;
  int m_act_mode;

  logic [CH-1:0] obs_pwm;
  logic          obs_cs;
  int            hi;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos      = 0;
    m_pend_p   = 255;
    m_act_p    = 255;
    m_act_mode = 0;
    for (int i = 0; i < CH; i++) begin
      m_pend_duty[i] = 0;
      m_act_duty[i]  = 0;
    end
  endtask

  task automatic model_step(output exp_t e);
    int pd[CH];
    int pp, c, plen;
    pd = m_pend_duty;
    if (bus.duty_we && (int'(bus.duty_sel) < CH)) pd[bus.duty_sel] = int'(bus.duty_data);
    pp = bus.period_we ? int'(bus.period_data) : m_pend_p;
    if (!bus.en || (m_pos == 0)) begin
      m_act_duty = pd;
      m_act_p    = pp;
      m_act_mode = int'(bus.mode);
    end
    m_pend_duty = pd;
    m_pend_p    = pp;
    e.cs = bus.en && (m_pos == 0);
    plen = (m_act_mode != 0) ? 2 * (m_act_p + 1) : m_act_p + 1;
    c    = ((m_act_mode != 0) && (m_pos > m_act_p)) ? 2 * m_act_p + 1 - m_pos : m_pos;
    for (int i = 0; i < CH; i++) begin
      e.pwm[i] = (bus.en && (c < m_act_duty[i])) ^ bus.pol[i];
    end
    m_pos = bus.en ? (m_pos + 1) % plen : 0;
  endtask

  task automatic tick();
    exp_t e;
    model_step(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e       = sb_q.pop_front();
    obs_pwm = bus.pwm_out;
    obs_cs  = bus.cycle_start;
    check_eq("sb_pwm", 32'(obs_pwm), 32'(e.pwm));
    check_eq("sb_cs", 32'(obs_cs), 32'(e.cs));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      hi += int'(obs_pwm[0]);
    end
  endtask

  task automatic wait_cs();
    int k;
    for (k = 0; k < 600; k++) begin
      tick();
      if (obs_cs) break;
    end
    if (k == 600) check_eq("wait_cs_timeout", 32'(0), 32'(1));
    hi = int'(obs_pwm[0]);
  endtask

  task automatic wr_duty(input int sel, input int val);
    bus.duty_we   = 1'b1;
    bus.duty_sel  = SW'(sel);
    bus.duty_data = W'(val);
    tick();
    bus.duty_we   = 1'b0;
  endtask

  // Duty0 and period written in one cycle; both must land.
  task automatic configure(input int p, input int d0, input int d1);
    bus.period_we   = 1'b1;
    bus.period_data = W'(p);
    wr_duty(0, d0);
    bus.period_we   = 1'b0;
    wr_duty(1, d1);
    wr_duty(2, 0);
    wr_duty(3, 0);
  endtask

  initial begin
    rst_n           = 1'b1;
    bus.en          = 1'b0;
    bus.mode        = 1'b0;
    bus.pol         = '0;
    bus.duty_we     = 1'b0;
    bus.duty_sel    = '0;
    bus.duty_data   = '0;
    bus.period_we   = 1'b0;
    bus.period_data = '0;
    hi              = 0;
    model_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("reset_pwm", 32'(bus.pwm_out), 32'(0));
    check_eq("reset_cs", 32'(bus.cycle_start), 32'(0));
    rst_n = 1'b1;

    // Test 1: mid-period asynchronous reset.
    configure(9, 3, 10);
    bus.en = 1'b1;
    run(2);
    check_eq("pre_rst_ch0", 32'(obs_pwm[0]), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_pwm", 32'(bus.pwm_out), 32'(0));
    check_eq("rst_mid_cs", 32'(bus.cycle_start), 32'(0));
    model_reset();
    #1 rst_n = 1'b1;
    tick();
    check_eq("rst_first_cs", 32'(obs_cs), 32'(1));
    run(3);

    // Test 2: edge mode, P=9, duty {0,0,10,3}.
    bus.en = 1'b0;
    configure(9, 3, 10);
    bus.en = 1'b1;
    wait_cs();
    run(9);
    check_eq("edge_ch0_hi", 32'(hi), 32'(3));
    check_eq("edge_ch1_const", 32'(obs_pwm[1]), 32'(1));
    check_eq("edge_ch23_low", 32'(obs_pwm[3:2]), 32'(0));
    run(1);
    check_eq("edge_cs_spacing", 32'(obs_cs), 32'(1));

    // Test 3: mid-period write waits for the next boundary.
    hi = int'(obs_pwm[0]);
    run(4);
    wr_duty(0, 7);
    hi += int'(obs_pwm[0]);
    run(4);
    check_eq("shadow_old_hi", 32'(hi), 32'(3));
    run(1);
    check_eq("shadow_cs", 32'(obs_cs), 32'(1));
    hi = int'(obs_pwm[0]);
    run(9);
    check_eq("shadow_new_hi", 32'(hi), 32'(7));

    // Test 4: write in the boundary cycle bypasses straight to active.
    wr_duty(0, 3);
    wait_cs();
    wait_cs();
    run(9);
    wr_duty(0, 7);
    check_eq("bypass_cs", 32'(obs_cs), 32'(1));
    hi = int'(obs_pwm[0]);
    run(9);
    check_eq("bypass_hi", 32'(hi), 32'(7));

    // Test 5: center mode, P=4, duty0=2.
    bus.mode = 1'b1;
    configure(4, 2, 0);
    wait_cs();
    run(9);
    check_eq("center_ch0_hi", 32'(hi), 32'(4));
    check_eq("center_wrap_ch0", 32'(obs_pwm[0]), 32'(1));
    run(1);
    check_eq("center_cs_spacing", 32'(obs_cs), 32'(1));
    check_eq("center_wrap_next", 32'(obs_pwm[0]), 32'(1));
    run(8);

    // Test 6: polarity with enable dropped and restored.
    bus.pol = 4'b0001;
    bus.en  = 1'b0;
    tick();
    check_eq("dis_pwm", 32'(obs_pwm), 32'(4'b0001));
    check_eq("dis_cs", 32'(obs_cs), 32'(0));
    run(3);
    bus.en = 1'b1;
    tick();
    check_eq("en_cs", 32'(obs_cs), 32'(1));
    check_eq("en_ch0_inv", 32'(obs_pwm[0]), 32'(0));
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
